dac_i2s_tx_scheduler: RTL and testbench

Single-clock I2S transmit scheduler for the PCM5102A. Derives BCK/LRCK from `cmn_clk`, accepts stereo 48-bit frames over a valid/ready handshake into a one-frame holding register, and serializes them MSB-first in 32-bit slots. It also sequences soft-mute (`xsmt`) around start-up, underrun and stop. It sits between the audio FIFO read side and the DAC pins.

---
 rtl/dac_i2s_tx_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_dac_i2s_tx_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_i2s_tx_scheduler.sv
// I2S transmit scheduler for the PCM5102A: one-frame holding register, 64-bit BCK frame, xsmt soft-mute sequencing.
// Latency: a frame accepted on s_tvalid/s_tready reaches din at the next frame boundary (worst case one frame later).
// Backpressure: s_tready is high only while the holding register is empty in RUN; it is registered and drops the cycle after a transfer.
module dac_i2s_tx_scheduler #(
    parameter int unsigned BCK_DIV      = 49,
    parameter int unsigned MUTE_FRAMES  = 4,
    parameter logic [15:0] UNDERRUN_SAT = 16'hFFFF
) (
    input  logic        cmn_clk,
    input  logic        cmn_rst,
    input  logic        enable,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic [47:0] s_tdata,
    output logic        pcm5102a_bck,
    output logic        pcm5102a_lrck,
    output logic        pcm5102a_din,
    output logic        pcm5102a_xsmt,
    output logic        frame_tick,
    output logic        underrun,
    output logic [15:0] underrun_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    localparam logic [7:0] DIV_LAST  = 8'(BCK_DIV - 1);
    localparam logic [7:0] MUTE_THR  = 8'(MUTE_FRAMES);

    logic [1:0]  r_state;
    logic [7:0]  r_div;
    logic        r_bck;
    logic        r_lrck;
    logic        r_din;
    logic        r_xsmt;
    logic [5:0]  r_bit_cnt;
    logic [63:0] r_shift;
    logic [47:0] r_hold;
    logic        r_hold_full;
    logic        r_tready;
    logic        r_frame_tick;
    logic        r_underrun;
    logic [15:0] r_underrun_cnt;
    logic [7:0]  r_consec;

    logic        w_div_tc;
    logic        w_fall;
    logic        w_bnd;
    logic        w_start;
    logic        w_stop_done;
    logic        w_load_evt;
    logic        w_xfer;
    logic [5:0]  w_bit_nxt;
    logic [7:0]  w_consec_inc;
    logic [1:0]  w_state_nxt;
    logic        w_hold_full_nxt;

    assign w_div_tc     = (r_div == DIV_LAST);
    // A falling bck event advances the bit position; bit 63 -> 0 is the frame boundary.
    assign w_fall       = (r_state != ST_IDLE) && w_div_tc && r_bck;
    assign w_bnd        = w_fall && (r_bit_cnt == 6'd63);
    // Leaving IDLE behaves like a boundary so the first frame starts cleanly at bit 0.
    assign w_start      = (r_state == ST_IDLE) && enable;
    // STOP only retires at a boundary if enable is still low; otherwise it resumes seamlessly.
    assign w_stop_done  = w_bnd && (r_state == ST_STOP) && !enable;
    assign w_load_evt   = w_start || (w_bnd && !w_stop_done);
    assign w_xfer       = s_tvalid && r_tready;
    assign w_bit_nxt    = r_bit_cnt + 6'd1;
    assign w_consec_inc = (r_consec == 8'hFF) ? r_consec : (r_consec + 8'd1);

    // Next-state selection for the run/stop sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (enable) w_state_nxt = ST_RUN;
            ST_RUN:  if (!enable) w_state_nxt = ST_STOP;
            ST_STOP: begin
                if (w_stop_done) begin
                    w_state_nxt = ST_IDLE;
                end else if (enable) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Holding register occupancy: a load empties it first, then a same-cycle transfer refills it.
    always_comb begin
        w_hold_full_nxt = r_hold_full;
        if (w_load_evt && r_hold_full) begin
            w_hold_full_nxt = 1'b0;
        end
        if (w_xfer) begin
            w_hold_full_nxt = 1'b1;
        end
    end

    // State register and registered ready, derived from next-cycle occupancy and state.
    always_ff @(posedge cmn_clk or posedge cmn_rst) begin
        if (cmn_rst) begin
            r_state  <= ST_IDLE;
            r_tready <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tready <= !w_hold_full_nxt && (w_state_nxt == ST_RUN);
        end
    end

    // One-frame holding register; contents survive IDLE so a held frame plays on re-enable.
    always_ff @(posedge cmn_clk or posedge cmn_rst) begin
        if (cmn_rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_hold <= s_tdata;
            end
            r_hold_full <= w_hold_full_nxt;
        end
    end

    // BCK divider and serializer; lrck/din move only on falling bck, din lags lrck by one BCK.
    always_ff @(posedge cmn_clk or posedge cmn_rst) begin
        if (cmn_rst) begin
            r_div     <= '0;
            r_bck     <= 1'b0;
            r_bit_cnt <= '0;
            r_lrck    <= 1'b0;
            r_din     <= 1'b0;
        end else if (w_start || w_stop_done) begin
            r_div     <= '0;
            r_bck     <= 1'b0;
            r_bit_cnt <= '0;
            r_lrck    <= 1'b0;
            r_din     <= 1'b0;
        end else if (r_state != ST_IDLE) begin
            r_div <= w_div_tc ? 8'd0 : (r_div + 8'd1);
            if (w_div_tc) begin
                r_bck <= ~r_bck;
            end
            if (w_fall) begin
                r_bit_cnt <= w_bit_nxt;
                r_lrck    <= w_bit_nxt[5];
                // Word bit (n-1) for new count n is the old count; at n=0 this is the previous pad bit.
                r_din     <= r_shift[6'd63 - r_bit_cnt];
            end
        end
    end

    // Shift word reload at each boundary: held stereo frame with 8-bit pads, or silence on underrun.
    always_ff @(posedge cmn_clk or posedge cmn_rst) begin
        if (cmn_rst) begin
            r_shift <= '0;
        end else if (w_load_evt) begin
            r_shift <= r_hold_full ? {r_hold[47:24], 8'h00, r_hold[23:0], 8'h00} : 64'd0;
        end
    end

    // Boundary bookkeeping: tick/underrun pulses, saturating counters and soft-mute control.
    always_ff @(posedge cmn_clk or posedge cmn_rst) begin
        if (cmn_rst) begin
            r_frame_tick   <= 1'b0;
            r_underrun     <= 1'b0;
            r_underrun_cnt <= '0;
            r_consec       <= '0;
            r_xsmt         <= 1'b0;
        end else begin
            r_frame_tick <= w_load_evt;
            r_underrun   <= w_load_evt && !r_hold_full;
            if (w_stop_done) begin
                r_xsmt <= 1'b0;
            end else if (w_load_evt) begin
                if (r_hold_full) begin
                    r_consec <= '0;
                    r_xsmt   <= 1'b1;
                end else begin
                    r_consec <= w_consec_inc;
                    if (r_underrun_cnt != UNDERRUN_SAT) begin
                        r_underrun_cnt <= r_underrun_cnt + 16'd1;
                    end
                    if (w_consec_inc >= MUTE_THR) begin
                        r_xsmt <= 1'b0;
                    end
                end
            end
        end
    end

    assign s_tready      = r_tready;
    assign pcm5102a_bck  = r_bck;
    assign pcm5102a_lrck = r_lrck;
    assign pcm5102a_din  = r_din;
    assign pcm5102a_xsmt = r_xsmt;
    assign frame_tick    = r_frame_tick;
    assign underrun      = r_underrun;
    assign underrun_cnt  = r_underrun_cnt;

endmodule

// File: tb/tb_dac_i2s_tx_scheduler.sv
// Testbench for dac_i2s_tx_scheduler: directed scenarios with randomized data/valid.
// Reference model tracks the frame as a phase counter and derives pin levels arithmetically.
// Every cycle all outputs are compared with the model; directed constant checks mark key events.
module tb_dac_i2s_tx_scheduler;

    localparam int          D    = 2;
    localparam int          MUTE = 2;
    localparam logic [15:0] SAT  = 16'd8;
    localparam int          F    = 128 * D;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_STOP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        vld = 1'b0;
    logic [47:0] dat = '0;
    logic        s_tready;
    logic        pcm5102a_bck, pcm5102a_lrck, pcm5102a_din, pcm5102a_xsmt;
    logic        frame_tick, underrun;
    logic [15:0] underrun_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_state;
    int          m_p;
    logic [63:0] m_word;
    logic [47:0] m_hold;
    bit          m_full, m_xsmt, m_tready, m_tick, m_und;
    int          m_consec;
    logic [15:0] m_ucnt;
    logic [63:0] cap;

    dac_i2s_tx_scheduler #(
        .BCK_DIV(D), .MUTE_FRAMES(MUTE), .UNDERRUN_SAT(SAT)
    ) dut (
        .cmn_clk(clk), .cmn_rst(rst), .enable(en),
        .s_tvalid(vld), .s_tready(s_tready), .s_tdata(dat),
        .pcm5102a_bck(pcm5102a_bck), .pcm5102a_lrck(pcm5102a_lrck),
        .pcm5102a_din(pcm5102a_din), .pcm5102a_xsmt(pcm5102a_xsmt),
        .frame_tick(frame_tick), .underrun(underrun), .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_p = 0; m_word = '0; m_hold = '0;
        m_full = 0; m_xsmt = 0; m_tready = 0; m_tick = 0; m_und = 0;
        m_consec = 0; m_ucnt = '0;
    endtask

    // Frame boundary rules: play the held frame, or play silence and count an underrun.
    task automatic model_load();
        m_tick = 1;
        if (m_full) begin
            m_word   = {m_hold[47:24], 8'h00, m_hold[23:0], 8'h00};
            m_full   = 0;
            m_consec = 0;
            m_xsmt   = 1;
        end else begin
            m_word = '0;
            m_und  = 1;
            if (m_ucnt != SAT) m_ucnt = m_ucnt + 16'd1;
            if (m_consec < 255) m_consec++;
            if (m_consec >= MUTE) m_xsmt = 0;
        end
    endtask

    task automatic model_clock();
        bit xfer;
        bit bnd;
        m_tick = 0;
        m_und  = 0;
        if (m_state == S_IDLE) begin
            if (en) begin
                model_load();
                m_state = S_RUN;
                m_p     = 0;
            end
        end else begin
            xfer = vld && m_tready;
            bnd  = (m_p == F - 1);
            if (bnd && m_state == S_STOP && !en) begin
                m_state = S_IDLE;
                m_xsmt  = 0;
                m_p     = 0;
            end else begin
                if (bnd) begin
                    model_load();
                    m_p = 0;
                end else begin
                    m_p++;
                end
                m_state = en ? S_RUN : S_STOP;
            end
            if (xfer) begin
                m_hold = dat;
                m_full = 1;
            end
        end
        m_tready = !m_full && (m_state == S_RUN);
    endtask

    task automatic check_all();
        int   n;
        logic eb, el, ed;
        n  = m_p / (2 * D);
        eb = 1'b0; el = 1'b0; ed = 1'b0;
        if (m_state != S_IDLE) begin
            eb = ((m_p % (2 * D)) >= D);
            el = (n >= 32);
            ed = (n == 0) ? 1'b0 : m_word[64 - n];
        end
        chk("bck",    64'(pcm5102a_bck),  64'(eb));
        chk("lrck",   64'(pcm5102a_lrck), 64'(el));
        chk("din",    64'(pcm5102a_din),  64'(ed));
        chk("xsmt",   64'(pcm5102a_xsmt), 64'(m_xsmt));
        chk("tready", 64'(s_tready),      64'(m_tready));
        chk("tick",   64'(frame_tick),    64'(m_tick));
        chk("undrn",  64'(underrun),      64'(m_und));
        chk("ucnt",   64'(underrun_cnt),  64'(m_ucnt));
        if (m_state != S_IDLE && (m_p % (2 * D)) == D) cap = {cap[62:0], pcm5102a_din};
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            if (rst) model_reset();
            else model_clock();
            #1;
            check_all();
        end
    endtask

    task automatic wait_tick();
        int k = 0;
        do begin
            step(1);
            k++;
        end while (!m_tick && k < F + 8);
        chk("tick_bound", 64'(frame_tick), 64'(1));
    endtask

    task automatic wait_p(input int target);
        int k = 0;
        do begin
            step(1);
            k++;
        end while (!(m_state != S_IDLE && m_p == target) && k < F + 8);
        chk("phase_bck_low", 64'(pcm5102a_bck), 64'(0));
    endtask

    task automatic do_reset();
        en = 0; vld = 0;
        rst = 1;
        step(2);
        rst = 0;
        step(1);
    endtask

    task automatic stream(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            vld = ($urandom_range(0, 3) != 0);
            dat = {16'($urandom()), $urandom()};
            step(1);
        end
    endtask

    initial begin
        logic [63:0] w;
        int k;
        model_reset();
        cap = '0;
        step(3);
        rst = 0;
        step(1);
        chk("rst_bck",   64'(pcm5102a_bck),  64'(0));
        chk("rst_xsmt",  64'(pcm5102a_xsmt), 64'(0));
        chk("rst_tready",64'(s_tready),      64'(0));
        chk("rst_ucnt",  64'(underrun_cnt),  64'(0));

        // Known pattern: first boundary underruns, second plays the frame
        dat = 48'h800001_7FFFFE; vld = 1; en = 1;
        step(1);
        chk("first_undrn", 64'(underrun), 64'(1));
        wait_tick();
        chk("xsmt_up", 64'(pcm5102a_xsmt), 64'(1));
        wait_tick();
        w = {24'h800001, 8'h00, 24'h7FFFFE, 8'h00};
        chk("slot_bits", cap, w >> 1);

        // Three underruns, then one real frame
        do_reset();
        en = 1;
        step(1);
        wait_tick();
        wait_tick();
        chk("ucnt3", 64'(underrun_cnt), 64'(3));
        chk("muted", 64'(pcm5102a_xsmt), 64'(0));
        dat = 48'h123456_654321; vld = 1;
        k = 0;
        do begin step(1); k++; end while (!m_full && k < 16);
        vld = 0;
        wait_tick();
        chk("xsmt_real", 64'(pcm5102a_xsmt), 64'(1));
        wait_tick();
        w = {24'h123456, 8'h00, 24'h654321, 8'h00};
        chk("slot_bits2", cap, w >> 1);

        // Random stream, starvation to mute, then recovery
        stream(6 * F);
        vld = 0;
        step(3 * F);
        chk("starved_mute", 64'(pcm5102a_xsmt), 64'(0));
        stream(3 * F);

        // Stop mid-frame with a held frame, then resume
        vld = 1; dat = {16'($urandom()), $urandom()};
        wait_p(10 * 2 * D);
        en = 0; vld = 0;
        k = 0;
        do begin step(1); k++; end while (m_state != S_IDLE && k < 2 * F);
        chk("stop_bck",  64'(pcm5102a_bck),  64'(0));
        chk("stop_lrck", 64'(pcm5102a_lrck), 64'(0));
        chk("stop_din",  64'(pcm5102a_din),  64'(0));
        chk("stop_xsmt", 64'(pcm5102a_xsmt), 64'(0));
        step(20);
        en = 1;
        step(1);
        chk("resume_no_undrn", 64'(underrun), 64'(0));
        chk("resume_xsmt", 64'(pcm5102a_xsmt), 64'(1));
        stream(2 * F);

        // Asynchronous reset at bit 40 with valid held high
        vld = 1;
        wait_p(40 * 2 * D);
        #2;
        rst = 1; en = 0;
        #1;
        chk("arst_bck",    64'(pcm5102a_bck),  64'(0));
        chk("arst_lrck",   64'(pcm5102a_lrck), 64'(0));
        chk("arst_din",    64'(pcm5102a_din),  64'(0));
        chk("arst_xsmt",   64'(pcm5102a_xsmt), 64'(0));
        chk("arst_tready", 64'(s_tready),      64'(0));
        chk("arst_ucnt",   64'(underrun_cnt),  64'(0));
        model_reset();
        step(2);
        rst = 0;
        step(2);
        en = 1;
        step(1);
        chk("post_rst_undrn", 64'(underrun), 64'(1));

        // Long underrun run: counter saturates without wrapping
        vld = 0;
        step(10 * F);
        chk("ucnt_sat", 64'(underrun_cnt), 64'(SAT));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
